// File: rtl/heartbeat_monitor.sv
`default_nettype none
// ============================================================================
// Module      : heartbeat_monitor
// Description : Issues a periodic start pulse to a request responder, waits a
//               bounded time for the rising edge of done, and tracks beats,
//               consecutive misses, liveness and a sticky alarm.
// Revision    : 1.0 - initial release
// ============================================================================
module heartbeat_monitor #(
    parameter int PERIOD     = 1000,
    parameter int TIMEOUT    = 64,
    parameter int MISS_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        clear_alarm,
    output logic        hb_start,
    input  logic        hb_done,
    input  logic [31:0] hb_result,
    output logic        alive,
    output logic        alarm,
    output logic [7:0]  miss_count,
    output logic [15:0] beat_count,
    output logic [31:0] last_result
);

    localparam logic [1:0] c_ST_IDLE        = 2'd0;
    localparam logic [1:0] c_ST_WAIT_PERIOD = 2'd1;
    localparam logic [1:0] c_ST_ISSUE       = 2'd2;
    localparam logic [1:0] c_ST_WAIT_DONE   = 2'd3;

    // Period counter holds PERIOD-1 down to 0; timeout counter counts 0..TIMEOUT-1.
    localparam int c_PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int c_TW = $clog2(TIMEOUT);

    localparam logic [c_PW-1:0] c_PER_LOAD   = c_PW'(PERIOD - 1);
    localparam logic [c_TW-1:0] c_TMO_LAST   = c_TW'(TIMEOUT - 1);
    localparam logic [7:0]      c_MISS_LIMIT = 8'(MISS_LIMIT);

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic            r_done_q;
    logic [c_PW-1:0] r_per_cnt;
    logic [c_TW-1:0] r_tmo_cnt;

    logic            r_hb_start;
    logic            r_alive;
    logic            r_alarm;
    logic [7:0]      r_miss_count;
    logic [15:0]     r_beat_count;
    logic [31:0]     r_last_result;

    logic            w_done_rise;
    logic            w_per_done;
    logic            w_tmo_last;
    logic            w_success;
    logic            w_timeout;
    logic            w_per_load;
    logic            w_start_next;
    logic [7:0]      w_miss_inc;
    logic            w_alarm_hit;

    // Only a fresh rising edge of done is accepted; a level left over from the
    // previous request never counts.
    assign w_done_rise = hb_done & ~r_done_q;
    assign w_per_done  = (r_per_cnt == '0);
    assign w_tmo_last  = (r_tmo_cnt == c_TMO_LAST);
    assign w_miss_inc  = (r_miss_count == 8'hFF) ? 8'hFF : (r_miss_count + 8'd1);
    assign w_alarm_hit = (w_miss_inc >= c_MISS_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (enable) begin
                    w_state_next = c_ST_WAIT_PERIOD;
                end
            end
            c_ST_WAIT_PERIOD: begin
                if (!enable) begin
                    w_state_next = c_ST_IDLE;
                end else if (w_per_done) begin
                    w_state_next = c_ST_ISSUE;
                end
            end
            c_ST_ISSUE: begin
                if (!enable) begin
                    w_state_next = c_ST_IDLE;
                end else begin
                    w_state_next = c_ST_WAIT_DONE;
                end
            end
            c_ST_WAIT_DONE: begin
                if (!enable) begin
                    w_state_next = c_ST_IDLE;
                end else if (w_done_rise || w_tmo_last) begin
                    w_state_next = c_ST_WAIT_PERIOD;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // Decoded actions; disabling abandons the request so neither outcome fires.
    always_comb begin
        w_success    = 1'b0;
        w_timeout    = 1'b0;
        w_per_load   = 1'b0;
        w_start_next = (w_state_next == c_ST_ISSUE);
        if (enable) begin
            if (r_state == c_ST_WAIT_DONE) begin
                w_success = w_done_rise;
                w_timeout = ~w_done_rise & w_tmo_last;
            end
            w_per_load = (r_state == c_ST_IDLE) | w_success | w_timeout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_done_q      <= 1'b0;
            r_per_cnt     <= '0;
            r_tmo_cnt     <= '0;
            r_hb_start    <= 1'b0;
            r_alive       <= 1'b0;
            r_alarm       <= 1'b0;
            r_miss_count  <= 8'd0;
            r_beat_count  <= 16'd0;
            r_last_result <= 32'd0;
        end else begin
            r_done_q   <= hb_done;
            r_hb_start <= w_start_next;

            if (w_per_load) begin
                r_per_cnt <= c_PER_LOAD;
            end else if ((r_state == c_ST_WAIT_PERIOD) && !w_per_done) begin
                r_per_cnt <= r_per_cnt - c_PW'(1);
            end

            if (r_state == c_ST_ISSUE) begin
                r_tmo_cnt <= '0;
            end else if (r_state == c_ST_WAIT_DONE) begin
                r_tmo_cnt <= r_tmo_cnt + c_TW'(1);
            end

            if (clear_alarm) begin
                r_alarm      <= 1'b0;
                r_miss_count <= 8'd0;
            end

            if (w_success) begin
                r_last_result <= hb_result;
                r_beat_count  <= r_beat_count + 16'd1;
                r_miss_count  <= 8'd0;
                r_alive       <= 1'b1;
            end

            // A timeout that reaches the limit overrides a simultaneous clear.
            if (w_timeout) begin
                r_alive <= 1'b0;
                if (w_alarm_hit) begin
                    r_miss_count <= w_miss_inc;
                    r_alarm      <= 1'b1;
                end else if (!clear_alarm) begin
                    r_miss_count <= w_miss_inc;
                end
            end
        end
    end

    assign hb_start    = r_hb_start;
    assign alive       = r_alive;
    assign alarm       = r_alarm;
    assign miss_count  = r_miss_count;
    assign beat_count  = r_beat_count;
    assign last_result = r_last_result;

endmodule
`default_nettype wire

// File: tb/tb_heartbeat_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_heartbeat_monitor
// Description : Directed table-driven bench for heartbeat_monitor with a
//               behavioural responder (normal / silent / stuck-high done).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_heartbeat_monitor;

    localparam int c_MODE_NORMAL = 0;
    localparam int c_MODE_SILENT = 1;
    localparam int c_MODE_STUCK  = 2;

    localparam logic [31:0] c_R1 = 32'hDEADBEEF;
    localparam logic [31:0] c_R2 = 32'h12345678;
    localparam logic [31:0] c_R3 = 32'hCAFEF00D;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        clear_alarm;
    logic        hb_start;
    logic        hb_done;
    logic [31:0] hb_result;
    logic        alive;
    logic        alarm;
    logic [7:0]  miss_count;
    logic [15:0] beat_count;
    logic [31:0] last_result;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    int          mode     = c_MODE_NORMAL;
    int          rsp_cnt  = 0;
    logic [31:0] rsp_val  = 32'd0;

    heartbeat_monitor #(
        .PERIOD     (4),
        .TIMEOUT    (8),
        .MISS_LIMIT (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .clear_alarm (clear_alarm),
        .hb_start    (hb_start),
        .hb_done     (hb_done),
        .hb_result   (hb_result),
        .alive       (alive),
        .alarm       (alarm),
        .miss_count  (miss_count),
        .beat_count  (beat_count),
        .last_result (last_result)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          adv;
        logic        en;
        logic        clr;
        int          md;
        logic [31:0] rsp;
        logic        x_start;
        logic        x_alive;
        logic        x_alarm;
        logic [7:0]  x_miss;
        logic [15:0] x_beat;
        logic [31:0] x_last;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // One clock: the responder reacts to hb_start as seen during the cycle
    // just ended; done drops one cycle after start and rises two cycles later.
    task automatic tick();
        logic st;
        st = hb_start;
        @(posedge clk);
        #1;
        cyc++;
        case (mode)
            c_MODE_SILENT: hb_done = 1'b0;
            c_MODE_STUCK:  hb_done = 1'b1;
            default: begin
                if (st === 1'b1) begin
                    hb_done = 1'b0;
                    rsp_cnt = 2;
                end else if (rsp_cnt > 0) begin
                    rsp_cnt--;
                    if (rsp_cnt == 0) begin
                        hb_done   = 1'b1;
                        hb_result = rsp_val;
                    end
                end
            end
        endcase
    endtask

    task automatic check_all(input string tag, input logic x_start, input logic x_alive,
                             input logic x_alarm, input logic [7:0] x_miss,
                             input logic [15:0] x_beat, input logic [31:0] x_last);
        chk({tag, ".hb_start"},    {31'd0, hb_start},   {31'd0, x_start});
        chk({tag, ".alive"},       {31'd0, alive},      {31'd0, x_alive});
        chk({tag, ".alarm"},       {31'd0, alarm},      {31'd0, x_alarm});
        chk({tag, ".miss_count"},  {24'd0, miss_count}, {24'd0, x_miss});
        chk({tag, ".beat_count"},  {16'd0, beat_count}, {16'd0, x_beat});
        chk({tag, ".last_result"}, last_result,         x_last);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // adv, en, clr, mode, rsp | start, alive, alarm, miss, beat, last
        vq.push_back('{0, 1'b1, 1'b0, c_MODE_NORMAL, c_R1, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0, 32'd0}); // c0
        vq.push_back('{4, 1'b1, 1'b0, c_MODE_NORMAL, c_R1, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0, 32'd0}); // c4
        vq.push_back('{1, 1'b1, 1'b0, c_MODE_NORMAL, c_R1, 1'b1, 1'b0, 1'b0, 8'd0, 16'd0, 32'd0}); // c5 start
        vq.push_back('{1, 1'b1, 1'b0, c_MODE_NORMAL, c_R1, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0, 32'd0}); // c6
        vq.push_back('{2, 1'b1, 1'b0, c_MODE_NORMAL, c_R1, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0, 32'd0}); // c8 done edge
        vq.push_back('{1, 1'b1, 1'b0, c_MODE_NORMAL, c_R1, 1'b0, 1'b1, 1'b0, 8'd0, 16'd1, c_R1});  // c9 beat
        vq.push_back('{3, 1'b1, 1'b0, c_MODE_NORMAL, c_R2, 1'b0, 1'b1, 1'b0, 8'd0, 16'd1, c_R1});  // c12
        vq.push_back('{1, 1'b1, 1'b0, c_MODE_NORMAL, c_R2, 1'b1, 1'b1, 1'b0, 8'd0, 16'd1, c_R1});  // c13 start
        vq.push_back('{4, 1'b1, 1'b0, c_MODE_NORMAL, c_R2, 1'b0, 1'b1, 1'b0, 8'd0, 16'd2, c_R2});  // c17 beat 2
        vq.push_back('{4, 1'b1, 1'b0, c_MODE_SILENT, c_R2, 1'b1, 1'b1, 1'b0, 8'd0, 16'd2, c_R2});  // c21 start
        vq.push_back('{8, 1'b1, 1'b0, c_MODE_SILENT, c_R2, 1'b0, 1'b1, 1'b0, 8'd0, 16'd2, c_R2});  // c29 deciding
        vq.push_back('{1, 1'b1, 1'b0, c_MODE_SILENT, c_R2, 1'b0, 1'b0, 1'b0, 8'd1, 16'd2, c_R2});  // c30 miss 1
        vq.push_back('{4, 1'b1, 1'b0, c_MODE_SILENT, c_R2, 1'b1, 1'b0, 1'b0, 8'd1, 16'd2, c_R2});  // c34 start
        vq.push_back('{9, 1'b1, 1'b0, c_MODE_SILENT, c_R2, 1'b0, 1'b0, 1'b0, 8'd2, 16'd2, c_R2});  // c43 miss 2
        vq.push_back('{4, 1'b1, 1'b0, c_MODE_SILENT, c_R2, 1'b1, 1'b0, 1'b0, 8'd2, 16'd2, c_R2});  // c47 start
        vq.push_back('{9, 1'b1, 1'b0, c_MODE_SILENT, c_R2, 1'b0, 1'b0, 1'b1, 8'd3, 16'd2, c_R2});  // c56 alarm
        vq.push_back('{1, 1'b1, 1'b1, c_MODE_SILENT, c_R2, 1'b0, 1'b0, 1'b0, 8'd0, 16'd2, c_R2});  // c57 cleared
        vq.push_back('{3, 1'b1, 1'b0, c_MODE_SILENT, c_R2, 1'b1, 1'b0, 1'b0, 8'd0, 16'd2, c_R2});  // c60 start
        vq.push_back('{9, 1'b1, 1'b0, c_MODE_SILENT, c_R2, 1'b0, 1'b0, 1'b0, 8'd1, 16'd2, c_R2});  // c69 miss 1
        vq.push_back('{4, 1'b1, 1'b0, c_MODE_STUCK,  c_R2, 1'b1, 1'b0, 1'b0, 8'd1, 16'd2, c_R2});  // c73 start
        vq.push_back('{9, 1'b1, 1'b0, c_MODE_STUCK,  c_R2, 1'b0, 1'b0, 1'b0, 8'd2, 16'd2, c_R2});  // c82 stuck miss
        vq.push_back('{4, 1'b1, 1'b0, c_MODE_STUCK,  c_R2, 1'b1, 1'b0, 1'b0, 8'd2, 16'd2, c_R2});  // c86 start
        vq.push_back('{8, 1'b1, 1'b0, c_MODE_STUCK,  c_R2, 1'b0, 1'b0, 1'b0, 8'd2, 16'd2, c_R2});  // c94 deciding
        vq.push_back('{1, 1'b1, 1'b1, c_MODE_STUCK,  c_R2, 1'b0, 1'b0, 1'b1, 8'd3, 16'd2, c_R2});  // c95 set beats clear
        vq.push_back('{4, 1'b1, 1'b0, c_MODE_NORMAL, c_R3, 1'b1, 1'b0, 1'b1, 8'd3, 16'd2, c_R2});  // c99 start
        vq.push_back('{4, 1'b1, 1'b0, c_MODE_NORMAL, c_R3, 1'b0, 1'b1, 1'b1, 8'd0, 16'd3, c_R3});  // c103 alarm sticky
        vq.push_back('{7, 1'b1, 1'b0, c_MODE_NORMAL, c_R3, 1'b0, 1'b1, 1'b1, 8'd0, 16'd3, c_R3});  // c110 deciding
        vq.push_back('{1, 1'b1, 1'b1, c_MODE_NORMAL, c_R3, 1'b0, 1'b1, 1'b0, 8'd0, 16'd4, c_R3});  // c111 clr+success
        vq.push_back('{6, 1'b1, 1'b0, c_MODE_NORMAL, c_R3, 1'b0, 1'b1, 1'b0, 8'd0, 16'd4, c_R3});  // c117 in WAIT_DONE
        vq.push_back('{1, 1'b0, 1'b0, c_MODE_NORMAL, c_R3, 1'b0, 1'b1, 1'b0, 8'd0, 16'd4, c_R3});  // c118 IDLE
        vq.push_back('{3, 1'b0, 1'b0, c_MODE_NORMAL, c_R3, 1'b0, 1'b1, 1'b0, 8'd0, 16'd4, c_R3});  // c121 late done ignored
        vq.push_back('{4, 1'b1, 1'b0, c_MODE_NORMAL, c_R3, 1'b0, 1'b1, 1'b0, 8'd0, 16'd4, c_R3});  // c125
        vq.push_back('{1, 1'b1, 1'b0, c_MODE_NORMAL, c_R3, 1'b1, 1'b1, 1'b0, 8'd0, 16'd4, c_R3});  // c126 = c121+P+1
        vq.push_back('{4, 1'b1, 1'b0, c_MODE_NORMAL, c_R3, 1'b0, 1'b1, 1'b0, 8'd0, 16'd5, c_R3});  // c130 beat 5

        // Reset held two cycles with enable high and done stuck high.
        rst         = 1'b1;
        enable      = 1'b1;
        clear_alarm = 1'b0;
        hb_done     = 1'b1;
        hb_result   = 32'h5A5A5A5A;
        mode        = c_MODE_STUCK;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_all($sformatf("reset%0d", i), 1'b0, 1'b0, 1'b0, 8'd0, 16'd0, 32'd0);
        end
        rst    = 1'b0;
        enable = 1'b0;
        mode   = c_MODE_NORMAL;
        tick();
        chk("idle.hb_start", {31'd0, hb_start}, 32'd0);

        cyc = 0;
        for (int i = 0; i < vq.size(); i++) begin
            enable      = vq[i].en;
            clear_alarm = vq[i].clr;
            mode        = vq[i].md;
            rsp_val     = vq[i].rsp;
            for (int k = 0; k < vq[i].adv; k++) begin
                tick();
            end
            check_all($sformatf("vec%0d", i), vq[i].x_start, vq[i].x_alive, vq[i].x_alarm,
                      vq[i].x_miss, vq[i].x_beat, vq[i].x_last);
        end

        // Reset in mid-operation returns every output to zero on the next edge.
        clear_alarm = 1'b0;
        rst = 1'b1;
        tick();
        check_all("midreset", 1'b0, 1'b0, 1'b0, 8'd0, 16'd0, 32'd0);
        rst = 1'b0;
        enable = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
